// File: rtl/minifloat_addsub_pipe.sv
// minifloat_addsub_pipe: 3-stage minifloat add/sub with valid/ready flow control.
// Rounding is selected by FPADD_ROUND_RNE_EN: defined gives round-to-nearest-even,
// undefined gives truncation. Both builds have the same latency.
module minifloat_addsub_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic [3:0]   out_flags
);
  localparam int SW = MAN_W + 1;
  localparam int XW = MAN_W + 4;
  localparam int LZW = $clog2(XW + 1);
  localparam logic [EXP_W-1:0] EMAX = '1;

  logic rdy2, rdy3;
  logic s1_v_q, s1_sign_q, s1_sub_q, s1_nan_q, s1_inf_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [SW-1:0] s1_sigl_q;
  logic [XW-1:0] s1_sigs_q;
  logic s2_v_q, s2_sign_q, s2_fl_q, s2_nan_q, s2_inf_q;
  logic [EXP_W:0] s2_exp_q;
  logic [XW-1:0] s2_sig_q;
  logic s3_v_q;
  logic [W-1:0] s3_res_q;
  logic [3:0] s3_flags_q;

  assign rdy3 = !s3_v_q || out_ready;
  assign rdy2 = !s2_v_q || rdy3;
  assign in_ready = !s1_v_q || rdy2;
  assign out_valid = s3_v_q;
  assign out_res = s3_res_q;
  assign out_flags = s3_flags_q;

  logic a_s, b_s, a_z, b_z, a_inf, b_inf, a_ge;
  logic [EXP_W-1:0] a_e, b_e, l_e, s_e, e_diff;
  logic [SW-1:0] a_sig, b_sig, l_sig, s_sig;
  logic [2*XW-1:0] wide;
  logic [XW-1:0] al;
  logic s1_sign_d;

  assign a_s = in_a[W-1];
  assign b_s = in_b[W-1] ^ in_op;
  assign a_e = in_a[W-2:MAN_W];
  assign b_e = in_b[W-2:MAN_W];
  assign a_z = a_e == '0;
  assign b_z = b_e == '0;
  assign a_inf = a_e == EMAX;
  assign b_inf = b_e == EMAX;
  assign a_sig = a_z ? '0 : {1'b1, in_a[MAN_W-1:0]};
  assign b_sig = b_z ? '0 : {1'b1, in_b[MAN_W-1:0]};
  assign a_ge = {a_e, a_sig} >= {b_e, b_sig};
  assign l_e = a_ge ? a_e : b_e;
  assign s_e = a_ge ? b_e : a_e;
  assign l_sig = a_ge ? a_sig : b_sig;
  assign s_sig = a_ge ? b_sig : a_sig;
  assign e_diff = l_e - s_e;
  assign wide = {s_sig, 3'b000, {XW{1'b0}}} >> e_diff;
  assign al = (int'(e_diff) >= MAN_W + 3) ? {{(XW-1){1'b0}}, |s_sig}
                                          : {wide[2*XW-1:XW+1], wide[XW] | (|wide[XW-1:0])};
  assign s1_sign_d = (a_inf || b_inf) ? (a_inf ? a_s : b_s) : (a_ge ? a_s : b_s);

  // S1: capture the swapped, aligned operand pair and special-case markers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_sub_q <= 1'b0;
      s1_nan_q <= 1'b0;
      s1_inf_q <= 1'b0;
      s1_exp_q <= '0;
      s1_sigl_q <= '0;
      s1_sigs_q <= '0;
    end else if (in_ready) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= s1_sign_d;
        s1_sub_q <= a_s ^ b_s;
        s1_nan_q <= a_inf && b_inf && (a_s ^ b_s);
        s1_inf_q <= a_inf || b_inf;
        s1_exp_q <= l_e;
        s1_sigl_q <= l_sig;
        s1_sigs_q <= al;
      end
    end
  end

  logic [XW:0] sum;
  logic [XW-1:0] diff, norm, add_n;
  logic [LZW-1:0] lz;
  logic under, flush;
  logic s2_sign_d, s2_fl_d;
  logic [EXP_W:0] s2_exp_d;
  logic [XW-1:0] s2_sig_d;

  assign sum = {1'b0, s1_sigl_q, 3'b000} + {1'b0, s1_sigs_q};
  assign diff = {s1_sigl_q, 3'b000} - s1_sigs_q;
  assign norm = diff << lz;
  assign add_n = sum[XW] ? {sum[XW:2], |sum[1:0]} : sum[XW-1:0];
  assign under = int'(s1_exp_q) <= int'(lz);
  assign flush = s1_sub_q && !s1_inf_q && (diff == '0 || under);

  // Leading-zero count of the difference; the highest set bit wins
  always_comb begin
    lz = '0;
    for (int i = 0; i < XW; i++) lz = diff[i] ? LZW'(XW - 1 - i) : lz;
  end

  // S2 next state: carry renormalise for add, left-normalise or flush for subtract
  always_comb begin
    s2_sign_d = flush ? 1'b0 : s1_sign_q;
    s2_exp_d = flush ? '0 : s1_sub_q ? {1'b0, s1_exp_q} - (EXP_W+1)'(lz)
                                     : {1'b0, s1_exp_q} + (EXP_W+1)'(sum[XW]);
    s2_sig_d = flush ? '0 : s1_sub_q ? norm : add_n;
    s2_fl_d = flush && diff != '0;
  end

  // S2: hold the normalised significand with guard/round/sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_fl_q <= 1'b0;
      s2_nan_q <= 1'b0;
      s2_inf_q <= 1'b0;
      s2_exp_q <= '0;
      s2_sig_q <= '0;
    end else if (rdy2) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_sign_q <= s2_sign_d;
        s2_fl_q <= s2_fl_d;
        s2_nan_q <= s1_nan_q;
        s2_inf_q <= s1_inf_q;
        s2_exp_q <= s2_exp_d;
        s2_sig_q <= s2_sig_d;
      end
    end
  end

  logic [SW:0] rsig;
  logic [EXP_W:0] rexp;
  logic [MAN_W-1:0] rman;
  logic grs, ovf;
  logic [W-1:0] s3_res_d;
  logic [3:0] s3_flags_d;

`ifdef FPADD_ROUND_RNE_EN
  assign rsig = {1'b0, s2_sig_q[XW-1:3]}
              + (SW+1)'(s2_sig_q[2] & (s2_sig_q[3] | s2_sig_q[1] | s2_sig_q[0]));
`else
  assign rsig = {1'b0, s2_sig_q[XW-1:3]};
`endif
  assign rexp = s2_exp_q + (EXP_W+1)'(rsig[SW]);
  assign rman = rsig[SW] ? rsig[MAN_W:1] : rsig[MAN_W-1:0];
  assign grs = |s2_sig_q[2:0];
  assign ovf = rexp >= {1'b0, EMAX};

  // S3 next state: pack, saturate on overflow, and apply special-value results
  always_comb begin
    s3_res_d = s2_nan_q ? {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}}
             : (s2_inf_q || ovf) ? {s2_sign_q, EMAX, {MAN_W{1'b0}}}
             : {s2_sign_q, rexp[EXP_W-1:0], rman};
    s3_flags_d = s2_nan_q ? 4'b1000 : s2_inf_q ? 4'b0000 : ovf ? 4'b0110
               : {2'b00, grs | s2_fl_q, rexp[EXP_W-1:0] == '0};
  end

  // S3: output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v_q <= 1'b0;
      s3_res_q <= '0;
      s3_flags_q <= '0;
    end else if (rdy3) begin
      s3_v_q <= s2_v_q;
      if (s2_v_q) begin
        s3_res_q <= s3_res_d;
        s3_flags_q <= s3_flags_d;
      end
    end
  end
endmodule

// File: tb/tb_minifloat_addsub_pipe.sv
// tb_minifloat_addsub_pipe: directed and backpressure checks for the minifloat adder
module tb_minifloat_addsub_pipe;
  logic clk = 0, rst_n = 0, in_valid = 0, in_op = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [7:0] in_a = 0, in_b = 0, out_res;
  logic [3:0] out_flags;
  int errors = 0, checks = 0;
  logic [11:0] got;
  int lat;

  always #5 clk = ~clk;

  minifloat_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags)
  );

`ifdef FPADD_ROUND_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact integer model: values in units of the smallest normal's LSB, then rounded
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic op);
    int ea, eb, va, vb, sum, mag, p, sh, kept, rem, half, e;
    logic sa, sb, sgn, inex, up;
    sa = a[7];
    sb = b[7] ^ op;
    ea = int'(a[6:3]);
    eb = int'(b[6:3]);
    if (ea == 15 || eb == 15) begin
      if (ea == 15 && eb == 15 && sa != sb) return 12'h87C;
      sgn = (ea == 15) ? sa : sb;
      return {4'b0000, sgn, 7'h78};
    end
    va = (ea == 0) ? 0 : ((8 + int'(a[2:0])) << (ea - 1));
    vb = (eb == 0) ? 0 : ((8 + int'(b[2:0])) << (eb - 1));
    if (sa) va = -va;
    if (sb) vb = -vb;
    sum = va + vb;
    mag = (sum < 0) ? -sum : sum;
    if (mag == 0) return {4'b0001, (sa == sb) ? sa : 1'b0, 7'h00};
    if (mag < 8) return 12'h300;
    sgn = sum < 0;
    p = 0;
    for (int i = 0; i < 31; i++) if ((mag >> i) != 0) p = i;
    sh = p - 3;
    e = p - 2;
    kept = mag >> sh;
    rem = mag - (kept << sh);
    half = (sh > 0) ? (1 << (sh - 1)) : 0;
    inex = rem != 0;
    up = RNE && sh > 0 && (rem > half || (rem == half && kept % 2 == 1));
    kept = kept + int'(up);
    if (kept == 16) begin
      kept = 8;
      e++;
    end
    if (e >= 15) return {4'b0110, sgn, 7'h78};
    return {2'b00, inex, 1'b0, sgn, 4'(e), 3'(kept)};
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic op,
                        output logic [11:0] res, output int cycles);
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    cycles = 1;
    while (!out_valid && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    res = {out_flags, out_res};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sa [8];
    logic [7:0] sb [8];
    logic so [8];
    logic [11:0] expq [$];
    int sent, done, cyc, inflight, stale;
    #12;
    check("reset_out", {out_flags, out_res}, 12'h000);
    check("reset_hs", {10'b0, out_valid, in_ready}, 12'h001);
    @(negedge clk);
    rst_n = 1;

    run_op(8'h38, 8'h38, 1'b0, got, lat);
    check("one_plus_one", got, 12'h040);
    check("latency", 12'(lat), 12'd3);
    run_op(8'h3C, 8'h28, 1'b0, got, lat);
    check("1p5_plus_0p25", got, 12'h03E);
    check("latency2", 12'(lat), 12'd3);
    run_op(8'h38, 8'h38, 1'b1, got, lat);
    check("one_minus_one", got, 12'h100);
    run_op(8'h38, 8'h18, 1'b0, got, lat);
    check("tie_even", got, 12'h238);
    run_op(8'h39, 8'h18, 1'b0, got, lat);
    check("tie_odd", got, RNE ? 12'h23A : 12'h239);
    run_op(8'h77, 8'h77, 1'b0, got, lat);
    check("overflow", got, 12'h678);
    run_op(8'h78, 8'h78, 1'b1, got, lat);
    check("inf_minus_inf", got, 12'h87C);
    run_op(8'hF8, 8'h38, 1'b0, got, lat);
    check("neg_inf_plus_one", got, 12'h0F8);
    run_op(8'h78, 8'h78, 1'b0, got, lat);
    check("inf_plus_inf", got, 12'h078);
    run_op(8'hB8, 8'h38, 1'b0, got, lat);
    check("opp_equal_zero", got, 12'h100);
    run_op(8'h09, 8'h08, 1'b1, got, lat);
    check("underflow_flush", got, 12'h300);
    run_op(8'h38, 8'h08, 1'b0, got, lat);
    check("sticky_only", got, 12'h238);
    run_op(8'h05, 8'h38, 1'b0, got, lat);
    check("denormal_as_zero", got, 12'h038);
    run_op(8'h40, 8'h38, 1'b1, got, lat);
    check("two_minus_one", got, 12'h038);

    sa[0] = 8'h38; sb[0] = 8'h38;
    sa[1] = 8'h3C; sb[1] = 8'h28;
    sa[2] = 8'h40; sb[2] = 8'h38;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a = sa[i];
      in_b = sb[i];
      in_op = 0;
      in_valid = 1;
      out_ready = 1;
    end
    @(negedge clk);
    in_valid = 0;
    out_ready = 0;
    #1;
    check("pre_reset_valid", {11'b0, out_valid}, 12'h001);
    rst_n = 0;
    #1;
    check("async_reset_out", {out_flags, out_res}, 12'h000);
    check("async_reset_hs", {10'b0, out_valid, in_ready}, 12'h001);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale", 12'(stale), 12'd0);
    run_op(8'h3C, 8'h28, 1'b0, got, lat);
    check("after_reset_op", got, 12'h03E);

    for (int i = 0; i < 8; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
      so[i] = 1'($urandom);
    end
    sent = 0;
    done = 0;
    cyc = 0;
    while (done < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      inflight = sent - done;
      in_valid = sent < 8;
      if (sent < 8) begin
        in_a = sa[sent];
        in_b = sb[sent];
        in_op = so[sent];
      end
      out_ready = (cyc >= 3 && cyc <= 7) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      if (inflight == 3 && !out_ready) check("full_stall_in_ready", {11'b0, in_ready}, 12'h000);
      if (out_valid) begin
        if (expq.size() == 0) check("unexpected_output", {11'b0, out_valid}, 12'h000);
        else begin
          check("stream_result", {out_flags, out_res}, expq[0]);
          if (out_ready) begin
            void'(expq.pop_front());
            done++;
          end
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(in_a, in_b, in_op));
        sent++;
      end
    end
    check("stream_count", 12'(done), 12'd8);
    @(negedge clk);
    in_valid = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
